// File: rtl/fetch_stage.sv
// Instruction-fetch stage: requests the instruction at pc_addr from a multi-cycle memory,
// loads it into IF/ID, parks it in a hold buffer under stall, drops wrong-path data on flush.
module fetch_stage #(
  parameter logic [15:0] NOP_INSTR   = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc_addr,
  output logic        pc_wen,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [15:0] imem_data,
  input  logic        stall,
  input  logic        flush,
  output logic        if_id_valid,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc,
  output logic        halted
);

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DISCARD = 2'd2,
    ST_HALTED  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [15:0] if_id_instr_q, if_id_instr_d;
  logic [15:0] if_id_pc_q, if_id_pc_d;
  logic [15:0] hold_instr_q, hold_instr_d;
  logic [15:0] hold_pc_q, hold_pc_d;
  logic [15:0] held_addr_q, held_addr_d;

  logic        pc_wen_s;
  logic        req_s;
  logic [15:0] addr_s;
  logic [15:0] next_pc_s;
  logic        data_is_halt_s;
  logic        hold_is_halt_s;

  assign next_pc_s      = pc_addr + 16'h0002;
  assign data_is_halt_s = (imem_data[15:12] == HALT_OPCODE);
  assign hold_is_halt_s = (hold_instr_q[15:12] == HALT_OPCODE);

  // Next-state and next-register computation for the fetch FSM.
  always_comb begin
    state_d       = state_q;
    if_id_valid_d = if_id_valid_q;
    if_id_instr_d = if_id_instr_q;
    if_id_pc_d    = if_id_pc_q;
    hold_instr_d  = hold_instr_q;
    hold_pc_d     = hold_pc_q;
    held_addr_d   = held_addr_q;
    pc_wen_s      = 1'b0;
    req_s         = 1'b0;
    addr_s        = pc_addr;

    if (flush) begin
      // Wrong-path work is discarded regardless of stall; the PC takes the redirect now.
      pc_wen_s      = 1'b1;
      if_id_valid_d = 1'b0;
      if_id_instr_d = NOP_INSTR;
      hold_instr_d  = NOP_INSTR;
      hold_pc_d     = 16'h0000;
    end else begin
      pc_wen_s = 1'b0;
    end

    case (state_q)
      ST_FETCH: begin
        req_s       = 1'b1;
        addr_s      = pc_addr;
        held_addr_d = pc_addr;
        if (flush) begin
          state_d = imem_rdy ? ST_FETCH : ST_DISCARD;
        end else if (imem_rdy) begin
          pc_wen_s = !data_is_halt_s;
          if (stall) begin
            hold_instr_d = imem_data;
            hold_pc_d    = next_pc_s;
            state_d      = ST_HOLD;
          end else begin
            if_id_valid_d = 1'b1;
            if_id_instr_d = imem_data;
            if_id_pc_d    = next_pc_s;
            state_d       = data_is_halt_s ? ST_HALTED : ST_FETCH;
          end
        end else if (!stall) begin
          if_id_valid_d = 1'b0;
          if_id_instr_d = NOP_INSTR;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (flush) begin
          state_d = ST_FETCH;
        end else if (!stall) begin
          if_id_valid_d = 1'b1;
          if_id_instr_d = hold_instr_q;
          if_id_pc_d    = hold_pc_q;
          state_d       = hold_is_halt_s ? ST_HALTED : ST_FETCH;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_DISCARD: begin
        // The outstanding request keeps its original address until the memory answers.
        req_s  = 1'b1;
        addr_s = held_addr_q;
        if (imem_rdy) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_DISCARD;
        end
        if (!flush && !stall) begin
          if_id_valid_d = 1'b0;
          if_id_instr_d = NOP_INSTR;
        end else begin
          if_id_valid_d = if_id_valid_d;
        end
      end
      ST_HALTED: begin
        if (flush) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_HALTED;
        end
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // State and pipeline registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_FETCH;
      if_id_valid_q <= 1'b0;
      if_id_instr_q <= NOP_INSTR;
      if_id_pc_q    <= 16'h0000;
      hold_instr_q  <= NOP_INSTR;
      hold_pc_q     <= 16'h0000;
      held_addr_q   <= 16'h0000;
    end else begin
      state_q       <= state_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc_q    <= if_id_pc_d;
      hold_instr_q  <= hold_instr_d;
      hold_pc_q     <= hold_pc_d;
      held_addr_q   <= held_addr_d;
    end
  end

  assign pc_wen      = rst & pc_wen_s;
  assign imem_req    = rst & req_s;
  assign imem_addr   = addr_s;
  assign if_id_valid = if_id_valid_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_pc    = if_id_pc_q;
  assign halted      = (state_q == ST_HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; the bench plays the PC block by driving pc_addr.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic [15:0] pc_addr;
  logic        pc_wen;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy;
  logic [15:0] imem_data;
  logic        stall;
  logic        flush;
  logic        if_id_valid;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc;
  logic        halted;

  int errors = 0;
  int checks = 0;

  fetch_stage dut (
    .clk(clk), .rst(rst), .pc_addr(pc_addr), .pc_wen(pc_wen),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdy(imem_rdy),
    .imem_data(imem_data), .stall(stall), .flush(flush),
    .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
    .if_id_pc(if_id_pc), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive inputs just after the falling edge so combinational outputs settle before sampling.
  task automatic drive(input logic [15:0] pc, input logic rdy, input logic [15:0] data,
                       input logic stl, input logic fl);
    @(negedge clk);
    pc_addr = pc; imem_rdy = rdy; imem_data = data; stall = stl; flush = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; pc_addr = 16'h0000; imem_rdy = 1'b1; imem_data = 16'h1234;
    stall = 1'b0; flush = 1'b0;
    #3;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
    checks++; if (pc_wen !== 1'b0) begin errors++; $display("FAIL reset_wen: got %b want 0", pc_wen); end
    tick();
    checks++; if ({if_id_valid, halted} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {if_id_valid, halted}); end
    checks++; if (if_id_instr !== 16'h0000) begin errors++; $display("FAIL reset_instr: got %h want 0000", if_id_instr); end
    checks++; if (if_id_pc !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h want 0000", if_id_pc); end
    @(negedge clk);
    imem_rdy = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_zero_wait();
    drive(16'h0000, 1'b1, 16'h1234, 1'b0, 1'b0);
    checks++; if ({imem_req, pc_wen} !== 2'b11) begin errors++; $display("FAIL zw_req_wen: got %b want 11", {imem_req, pc_wen}); end
    checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL zw_addr: got %h want 0000", imem_addr); end
    tick();
    checks++; if ({if_id_valid, if_id_instr, if_id_pc} !== {1'b1, 16'h1234, 16'h0002}) begin
      errors++; $display("FAIL zw_ifid: got %b/%h/%h want 1/1234/0002", if_id_valid, if_id_instr, if_id_pc); end
  endtask

  task automatic test_two_wait();
    for (int c = 1; c <= 3; c++) begin
      drive(16'h0010, (c == 3) ? 1'b1 : 1'b0, (c == 3) ? 16'h2222 : 16'hDEAD, 1'b0, 1'b0);
      checks++; if (imem_addr !== 16'h0010) begin errors++; $display("FAIL tw_addr c%0d: got %h want 0010", c, imem_addr); end
      checks++; if (pc_wen !== ((c == 3) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL tw_wen c%0d: got %b", c, pc_wen); end
      tick();
      if (c < 3) begin
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL tw_bubble c%0d: got %b want 0", c, if_id_valid); end
      end else begin
        checks++; if ({if_id_valid, if_id_instr, if_id_pc} !== {1'b1, 16'h2222, 16'h0012}) begin
          errors++; $display("FAIL tw_capture: got %b/%h/%h want 1/2222/0012", if_id_valid, if_id_instr, if_id_pc); end
      end
    end
  endtask

  task automatic test_stall();
    drive(16'h0012, 1'b1, 16'hABCD, 1'b1, 1'b0);
    checks++; if (pc_wen !== 1'b1) begin errors++; $display("FAIL st_wen: got %b want 1", pc_wen); end
    tick();
    checks++; if ({if_id_valid, if_id_instr, if_id_pc} !== {1'b1, 16'h2222, 16'h0012}) begin
      errors++; $display("FAIL st_hold_ifid: got %b/%h/%h want 1/2222/0012", if_id_valid, if_id_instr, if_id_pc); end
    drive(16'h0014, 1'b0, 16'h0000, 1'b1, 1'b0);
    checks++; if ({imem_req, pc_wen} !== 2'b00) begin errors++; $display("FAIL st_req_off: got %b want 00", {imem_req, pc_wen}); end
    tick();
    checks++; if (if_id_instr !== 16'h2222) begin errors++; $display("FAIL st_still: got %h want 2222", if_id_instr); end
    drive(16'h0014, 1'b0, 16'h0000, 1'b0, 1'b0);
    checks++; if (pc_wen !== 1'b0) begin errors++; $display("FAIL st_release_wen: got %b want 0", pc_wen); end
    tick();
    checks++; if ({if_id_valid, if_id_instr, if_id_pc} !== {1'b1, 16'hABCD, 16'h0014}) begin
      errors++; $display("FAIL st_release: got %b/%h/%h want 1/ABCD/0014", if_id_valid, if_id_instr, if_id_pc); end
  endtask

  task automatic test_flush_outstanding();
    drive(16'h0020, 1'b0, 16'h0000, 1'b0, 1'b0);
    checks++; if (imem_addr !== 16'h0020) begin errors++; $display("FAIL fl_addr0: got %h want 0020", imem_addr); end
    tick();
    drive(16'h0020, 1'b0, 16'h0000, 1'b0, 1'b1);
    checks++; if ({pc_wen, imem_addr} !== {1'b1, 16'h0020}) begin errors++; $display("FAIL fl_flush: got %b/%h want 1/0020", pc_wen, imem_addr); end
    tick();
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL fl_clear: got %b want 0", if_id_valid); end
    for (int c = 2; c <= 4; c++) begin
      drive(16'h0100, (c == 4) ? 1'b1 : 1'b0, 16'h5555, 1'b0, 1'b0);
      checks++; if ({imem_req, pc_wen, imem_addr} !== {1'b1, 1'b0, 16'h0020}) begin
        errors++; $display("FAIL fl_discard c%0d: got %b/%b/%h want 1/0/0020", c, imem_req, pc_wen, imem_addr); end
      tick();
    end
    checks++; if ({if_id_valid, if_id_instr} !== {1'b0, 16'h0000}) begin
      errors++; $display("FAIL fl_dropped: got %b/%h want 0/0000", if_id_valid, if_id_instr); end
    drive(16'h0100, 1'b0, 16'h0000, 1'b0, 1'b0);
    checks++; if ({imem_req, imem_addr} !== {1'b1, 16'h0100}) begin errors++; $display("FAIL fl_redirect: got %b/%h want 1/0100", imem_req, imem_addr); end
    tick();
  endtask

  task automatic test_wrap();
    drive(16'hFFFE, 1'b1, 16'h1111, 1'b0, 1'b0);
    tick();
    checks++; if ({if_id_instr, if_id_pc} !== {16'h1111, 16'h0000}) begin
      errors++; $display("FAIL wrap: got %h/%h want 1111/0000", if_id_instr, if_id_pc); end
  endtask

  task automatic test_halt();
    drive(16'h0040, 1'b1, 16'hF000, 1'b0, 1'b0);
    checks++; if ({imem_req, pc_wen} !== 2'b10) begin errors++; $display("FAIL ht_wen: got %b want 10", {imem_req, pc_wen}); end
    tick();
    checks++; if ({halted, if_id_valid, if_id_instr} !== {1'b1, 1'b1, 16'hF000}) begin
      errors++; $display("FAIL ht_enter: got %b/%b/%h want 1/1/F000", halted, if_id_valid, if_id_instr); end
    drive(16'h0040, 1'b1, 16'h1234, 1'b0, 1'b0);
    checks++; if ({imem_req, pc_wen} !== 2'b00) begin errors++; $display("FAIL ht_idle: got %b want 00", {imem_req, pc_wen}); end
    tick();
    checks++; if ({halted, if_id_instr} !== {1'b1, 16'hF000}) begin errors++; $display("FAIL ht_stay: got %b/%h want 1/F000", halted, if_id_instr); end
    drive(16'h0040, 1'b0, 16'h0000, 1'b0, 1'b1);
    checks++; if (pc_wen !== 1'b1) begin errors++; $display("FAIL ht_flush_wen: got %b want 1", pc_wen); end
    tick();
    checks++; if ({halted, if_id_valid, if_id_instr} !== {1'b0, 1'b0, 16'h0000}) begin
      errors++; $display("FAIL ht_exit: got %b/%b/%h want 0/0/0000", halted, if_id_valid, if_id_instr); end
  endtask

  task automatic test_reset_mid();
    drive(16'h0050, 1'b1, 16'h3333, 1'b0, 1'b0);
    tick();
    drive(16'h0060, 1'b0, 16'h0000, 1'b1, 1'b0);
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rm_wait_req: got %b want 1", imem_req); end
    #1 rst = 1'b0;
    #1;
    checks++; if ({imem_req, pc_wen, if_id_valid, halted} !== 4'b0000) begin
      errors++; $display("FAIL rm_async_flags: got %b want 0000", {imem_req, pc_wen, if_id_valid, halted}); end
    checks++; if ({if_id_instr, if_id_pc} !== {16'h0000, 16'h0000}) begin
      errors++; $display("FAIL rm_async_regs: got %h/%h want 0000/0000", if_id_instr, if_id_pc); end
    @(negedge clk);
    rst = 1'b1;
    drive(16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    checks++; if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin errors++; $display("FAIL rm_restart: got %b/%h want 1/0000", imem_req, imem_addr); end
    tick();
    drive(16'h0000, 1'b1, 16'h7777, 1'b0, 1'b0);
    tick();
    checks++; if ({if_id_valid, if_id_instr, if_id_pc} !== {1'b1, 16'h7777, 16'h0002}) begin
      errors++; $display("FAIL rm_fetch: got %b/%h/%h want 1/7777/0002", if_id_valid, if_id_instr, if_id_pc); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_two_wait();
    test_stall();
    test_flush_outstanding();
    test_wrap();
    test_halt();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
